multi_clk_div: RTL

- Parametrised, synthesizable successor to the fixed simulation clock generator.
- From one fast clock (BUS_CLK), derives NCH registered divided clocks. Each channel has a programmable half-period, a phase offset and an enable.
- All channels are realigned every programmable super-period and on SYNC.
- Also provides per-channel rising-edge strobes, the super-period counter, a free-running timestamp and a LOCKED flag.

---
 rtl/multi_clk_div.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/multi_clk_div.sv
// Multi-channel programmable clock divider: NCH registered divided clocks realigned every
// super-period and on SYNC, with rising-edge strobes, super counter, timestamp and LOCKED.
module multi_clk_div #(
  parameter int NCH       = 5,
  parameter int CNT_WIDTH = 8,
  parameter int TS_WIDTH  = 64
) (
  input  logic                     BUS_CLK,
  input  logic                     BUS_RST,
  input  logic [CNT_WIDTH-1:0]     SUPER_PERIOD,
  input  logic [NCH*CNT_WIDTH-1:0] HALF_PERIOD,
  input  logic [NCH*CNT_WIDTH-1:0] PHASE,
  input  logic [NCH-1:0]           ENABLE,
  input  logic                     SYNC,
  output logic [NCH-1:0]           CLK_OUT,
  output logic [NCH-1:0]           STROBE,
  output logic [CNT_WIDTH-1:0]     CNT,
  output logic [TS_WIDTH-1:0]      TIMESTAMP,
  output logic                     LOCKED
);

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  logic                     load_pending_q, load_pending_d;
  logic [CNT_WIDTH-1:0]     cnt_q, cnt_d;
  logic [CNT_WIDTH-1:0]     sh_super_q, sh_super_d;
  logic [NCH*CNT_WIDTH-1:0] sh_half_q, sh_half_d;
  logic [NCH*CNT_WIDTH-1:0] sh_phase_q, sh_phase_d;
  logic [NCH-1:0]           sh_en_q, sh_en_d;
  logic [NCH*CNT_WIDTH-1:0] dcnt_q, dcnt_d;
  logic [NCH-1:0]           clk_q, clk_d;
  logic [NCH-1:0]           strobe_q, strobe_d;
  logic [TS_WIDTH-1:0]      ts_q, ts_d;
  logic                     locked_q, locked_d;
  logic [CNT_WIDTH-1:0]     s_last;
  logic                     wrap;

  always_comb begin : next_state
    logic [CNT_WIDTH-1:0] half_i;
    logic [CNT_WIDTH-1:0] phase_i;
    logic [CNT_WIDTH-1:0] dcnt_i;
    logic                 tog_i;

    ts_d           = ts_q + TS_WIDTH'(1);
    load_pending_d = load_pending_q;
    cnt_d          = cnt_q;
    locked_d       = locked_q;
    clk_d          = clk_q;
    strobe_d       = '0;
    dcnt_d         = dcnt_q;
    sh_super_d     = sh_super_q;
    sh_half_d      = sh_half_q;
    sh_phase_d     = sh_phase_q;
    sh_en_d        = sh_en_q;
    half_i         = '0;
    phase_i        = '0;
    dcnt_i         = '0;
    tog_i          = 1'b0;

    // A programmed super-period of 0 wraps the subtraction to all-ones, i.e. 2^CNT_WIDTH cycles.
    s_last = sh_super_q - CNT_ONE;
    wrap   = !load_pending_q && (cnt_q == s_last);

    if (load_pending_q || SYNC || wrap) begin
      sh_super_d = SUPER_PERIOD;
      sh_half_d  = HALF_PERIOD;
      sh_phase_d = PHASE;
      sh_en_d    = ENABLE;
    end

    if (SYNC) begin
      load_pending_d = 1'b0;
      cnt_d          = '0;
      dcnt_d         = '0;
      clk_d          = '0;
      locked_d       = 1'b0;
    end else if (load_pending_q) begin
      load_pending_d = 1'b0;
      cnt_d          = '0;
    end else begin
      cnt_d = wrap ? '0 : cnt_q + CNT_ONE;
      if (wrap) locked_d = 1'b1;
      // dcnt counts cycles since the last toggle, so toggles land exactly HALF cycles apart.
      for (int i = 0; i < NCH; i++) begin
        half_i  = sh_half_q[i*CNT_WIDTH +: CNT_WIDTH];
        phase_i = sh_phase_q[i*CNT_WIDTH +: CNT_WIDTH];
        dcnt_i  = dcnt_q[i*CNT_WIDTH +: CNT_WIDTH];
        tog_i   = 1'b0;
        if (!sh_en_q[i] || half_i == '0) begin
          clk_d[i]                          = 1'b0;
          dcnt_d[i*CNT_WIDTH +: CNT_WIDTH] = '0;
        end else if (cnt_q == phase_i) begin
          tog_i                             = 1'b1;
          dcnt_d[i*CNT_WIDTH +: CNT_WIDTH] = '0;
        end else if (cnt_q > phase_i) begin
          if (dcnt_i == half_i - CNT_ONE) begin
            tog_i                             = 1'b1;
            dcnt_d[i*CNT_WIDTH +: CNT_WIDTH] = '0;
          end else begin
            dcnt_d[i*CNT_WIDTH +: CNT_WIDTH] = dcnt_i + CNT_ONE;
          end
        end
        if (tog_i) begin
          clk_d[i]    = ~clk_q[i];
          strobe_d[i] = ~clk_q[i];
        end
      end
    end
  end

  always_ff @(posedge BUS_CLK or posedge BUS_RST) begin
    if (BUS_RST) begin
      load_pending_q <= 1'b1;
      cnt_q          <= '0;
      sh_super_q     <= '0;
      sh_half_q      <= '0;
      sh_phase_q     <= '0;
      sh_en_q        <= '0;
      dcnt_q         <= '0;
      clk_q          <= '0;
      strobe_q       <= '0;
      ts_q           <= '0;
      locked_q       <= 1'b0;
    end else begin
      load_pending_q <= load_pending_d;
      cnt_q          <= cnt_d;
      sh_super_q     <= sh_super_d;
      sh_half_q      <= sh_half_d;
      sh_phase_q     <= sh_phase_d;
      sh_en_q        <= sh_en_d;
      dcnt_q         <= dcnt_d;
      clk_q          <= clk_d;
      strobe_q       <= strobe_d;
      ts_q           <= ts_d;
      locked_q       <= locked_d;
    end
  end

  assign CLK_OUT   = clk_q;
  assign STROBE    = strobe_q;
  assign CNT       = cnt_q;
  assign TIMESTAMP = ts_q;
  assign LOCKED    = locked_q;

endmodule
